// File: rtl/dram_burst_responder.sv
// dram_burst_responder
//   Wishbone-side responder in front of a 256-word SDRAM storage array.
//   Accepts a single-cycle request. A read streams BURST_LEN consecutive
//   words after a CAS latency. A write performs one single-word store.
//   Storage is external and reached through a synchronous memory port with
//   a 1-cycle read latency.
//
// Ports
//   wb_clk_i, wb_rst_n        clock, asynchronous active-low reset
//   wbs_stb_i/cyc_i/we_i      request qualifiers (we=1 write, we=0 burst read)
//   wbs_sel_i, wbs_dat_i      write byte enables and write data
//   wbs_adr_i                 [31:22] tag, [9:8] bank, [7:0] byte column
//   wbs_ack_o                 one-cycle acknowledge, both reads and writes
//   burst_en_o, wbs_dat_o     burst word valid and burst read data
//   mem_en, mem_we, mem_addr  storage read/write enables, word address
//   mem_wdata, mem_wstrb      storage write data and byte strobes
//   mem_rdata                 storage read data, one cycle after mem_en
module dram_burst_responder #(
    parameter int         BURST_LEN = 4,
    parameter int         CAS_LAT   = 2,
    parameter logic [9:0] ADR_TAG   = 10'h1E0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic        burst_en_o,
    output logic [31:0] wbs_dat_o,
    output logic        mem_en,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACK, WAIT, BURST} state_t;

    // Cycle indices relative to the request cycle T (T+1 is the ack cycle).
    localparam logic [4:0] EN_LO = 5'(CAS_LAT);
    localparam logic [4:0] EN_HI = 5'(CAS_LAT + BURST_LEN - 1);
    localparam logic [4:0] BU_LO = 5'(CAS_LAT + 2);
    localparam logic [4:0] BU_HI = 5'(CAS_LAT + BURST_LEN + 1);
    localparam logic [4:0] DONE  = 5'(CAS_LAT + BURST_LEN + 2);

    state_t      state_q;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  bank_q;
    logic [5:0]  word_q;      // column word index of the next read issue
    logic        we_q;
    logic        req;
    logic        en_d, bst_d;

    logic        ack_q, bst_q, en_q, we_out_q;
    logic [31:0] dat_q, wdata_q;
    logic [7:0]  addr_q;
    logic [3:0]  wstrb_q;

    logic        unused_adr;
    assign unused_adr = ^{wbs_adr_i[21:10], wbs_adr_i[1:0]};

    always_comb begin
        req   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:22] == ADR_TAG);
        // cnt_d is the index of the cycle whose outputs are being registered.
        cnt_d = (state_q == IDLE) ? 5'd1 : cnt_q + 5'd1;
        en_d  = (cnt_d >= EN_LO) && (cnt_d <= EN_HI);
        bst_d = (cnt_d >= BU_LO) && (cnt_d <= BU_HI);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bank_q   <= '0;
            word_q   <= '0;
            we_q     <= 1'b0;
            ack_q    <= 1'b0;
            bst_q    <= 1'b0;
            en_q     <= 1'b0;
            we_out_q <= 1'b0;
            dat_q    <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            wstrb_q  <= '0;
        end else begin
            ack_q    <= 1'b0;
            bst_q    <= 1'b0;
            en_q     <= 1'b0;
            we_out_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q <= ACK;
                        cnt_q   <= cnt_d;
                        ack_q   <= 1'b1;
                        bank_q  <= wbs_adr_i[9:8];
                        we_q    <= wbs_we_i;
                        word_q  <= wbs_adr_i[7:2];
                        if (wbs_we_i) begin
                            we_out_q <= 1'b1;
                            addr_q   <= wbs_adr_i[9:2];
                            wdata_q  <= wbs_dat_i;
                            wstrb_q  <= wbs_sel_i;
                        end else if (en_d) begin
                            // CAS_LAT==1: first read issues alongside the ack.
                            en_q   <= 1'b1;
                            addr_q <= wbs_adr_i[9:2];
                            word_q <= wbs_adr_i[7:2] + 6'd1;
                        end
                    end
                end
                default: begin
                    if (we_q) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (en_d) begin
                            // 6-bit word index wraps the column inside the bank.
                            en_q   <= 1'b1;
                            addr_q <= {bank_q, word_q};
                            word_q <= word_q + 6'd1;
                        end
                        if (bst_d) begin
                            bst_q <= 1'b1;
                            dat_q <= mem_rdata;
                        end
                        if (cnt_d == DONE) state_q <= IDLE;
                        else if (bst_d)    state_q <= BURST;
                        else               state_q <= WAIT;
                    end
                end
            endcase
        end
    end

    assign wbs_ack_o  = ack_q;
    assign burst_en_o = bst_q;
    assign wbs_dat_o  = dat_q;
    assign mem_en     = en_q;
    assign mem_we     = we_out_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;

endmodule
